// File: rtl/burst_mem_pkg.sv
// Shared types and helpers for the burst memory responder.
package burst_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LAT,
      BURST,
      DONE
   } burst_mem_state_t;

   typedef enum logic {
      OP_RD,
      OP_WR
   } burst_mem_op_t;

   localparam int BEAT_W = 64;

   function automatic int beats(input int s_off);
      return (1 << s_off) / 8;
   endfunction

endpackage

// File: rtl/burst_mem_array.sv
// Line-organised backing store with one beat-granular port.
// Read data is registered and held at zero when no read is issued.
module burst_mem_array
   import burst_mem_pkg::*;
#(
   parameter  int DEPTH_LINES = 256,
   parameter  int BEATS       = 4,
   localparam int IDX_W       = $clog2(DEPTH_LINES),
   localparam int BT_W        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  idx,
   input  logic [BT_W-1:0]   beat,
   input  logic              we,
   input  logic              re,
   input  logic [BEAT_W-1:0] wdata,
   output logic [BEAT_W-1:0] rdata
);

   localparam int WORDS = DEPTH_LINES * (1 << BT_W);

   logic [BEAT_W-1:0]       r_mem [WORDS];
   logic [BEAT_W-1:0]       r_rdata;
   logic [IDX_W+BT_W-1:0]   w_addr;

   assign w_addr = {idx, beat};
   assign rdata  = r_rdata;

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[w_addr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= re ? r_mem[w_addr] : '0;
      end
   end

endmodule

// File: rtl/burst_mem_responder.sv
// Burst pmem responder: FSM, counters and error flag over burst_mem_array.
// Optional BURST_MEM_HOLD_CHECK_EN enables request stability checking.
module burst_mem_responder
   import burst_mem_pkg::*;
#(
   parameter int s_offset    = 5,
   parameter int DEPTH_LINES = 256,
   parameter int READ_LAT    = 3,
   parameter int WRITE_LAT   = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [31:0]         mem_address,
   input  logic [BEAT_W-1:0]   mem_wdata,
   output logic [BEAT_W-1:0]   mem_rdata,
   output logic                mem_resp,
   output logic                err_o
);

   localparam int BEATS   = beats(s_offset);
   localparam int IDX_W   = $clog2(DEPTH_LINES);
   localparam int BT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int CNT_W   = $clog2(LAT_MAX + 1);

   burst_mem_state_t  r_state, w_state_nx;
   burst_mem_op_t     r_op, w_op_nx;
   logic [IDX_W-1:0]  r_idx, w_idx_nx;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
   logic [BT_W-1:0]   r_beat, w_beat_nx;
   logic              r_err, w_err_nx;
   logic              w_we;
   logic              w_re;
   logic [BT_W-1:0]   w_arr_beat;
   logic              w_viol;
   logic              w_unused;

   assign w_unused = ^{mem_address[s_offset-1:0],
                       mem_address[31:s_offset+IDX_W]};

`ifdef BURST_MEM_HOLD_CHECK_EN
   logic [31-s_offset:0] r_ahi;
   logic                 w_own;
   logic                 w_oth;

   assign w_own  = (r_op == OP_WR) ? mem_write : mem_read;
   assign w_oth  = (r_op == OP_WR) ? mem_read : mem_write;
   assign w_viol = ((r_state == LAT) || (r_state == BURST)) &&
                   (!w_own || w_oth ||
                    (mem_address[31:s_offset] != r_ahi));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ahi <= '0;
      end else if (r_state == IDLE) begin
         r_ahi <= mem_address[31:s_offset];
      end
   end
`else
   assign w_viol = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_op    <= OP_RD;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_beat  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_op    <= w_op_nx;
         r_idx   <= w_idx_nx;
         r_cnt   <= w_cnt_nx;
         r_beat  <= w_beat_nx;
         r_err   <= w_err_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_op_nx    = r_op;
      w_idx_nx   = r_idx;
      w_cnt_nx   = r_cnt;
      w_beat_nx  = r_beat;
      w_err_nx   = r_err;
      w_we       = 1'b0;
      w_re       = 1'b0;
      w_arr_beat = r_beat;
      unique case (r_state)
         IDLE: begin
            if (mem_read && mem_write) begin
               w_err_nx = 1'b1;
            end else if (mem_read || mem_write) begin
               w_op_nx    = mem_write ? OP_WR : OP_RD;
               w_idx_nx   = mem_address[s_offset +: IDX_W];
               w_cnt_nx   = mem_write ? CNT_W'(WRITE_LAT - 1)
                                      : CNT_W'(READ_LAT - 1);
               w_state_nx = LAT;
            end
         end
         LAT: begin
            if (w_viol) begin
               w_err_nx   = 1'b1;
               w_state_nx = DONE;
            end else if (r_cnt == '0) begin
               w_state_nx = BURST;
               w_beat_nx  = '0;
               // Registered read: fetch beat 0 one cycle ahead.
               w_arr_beat = '0;
               w_re       = (r_op == OP_RD);
            end else begin
               w_cnt_nx = r_cnt - 1'b1;
            end
         end
         BURST: begin
            if (w_viol) begin
               w_err_nx   = 1'b1;
               w_state_nx = DONE;
            end else begin
               w_we = (r_op == OP_WR);
               if (r_beat == BT_W'(BEATS - 1)) begin
                  w_state_nx = DONE;
               end else begin
                  w_beat_nx = r_beat + 1'b1;
                  if (r_op == OP_RD) begin
                     w_arr_beat = r_beat + 1'b1;
                     w_re       = 1'b1;
                  end
               end
            end
         end
         DONE: begin
            w_state_nx = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   burst_mem_array #(
      .DEPTH_LINES (DEPTH_LINES),
      .BEATS       (BEATS)
   ) u_array (
      .clk   (clk),
      .rst_n (reset_n),
      .idx   (r_idx),
      .beat  (w_arr_beat),
      .we    (w_we),
      .re    (w_re),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   assign mem_resp = (r_state == BURST);
   assign err_o    = r_err;

endmodule
